// File: rtl/crd_rr_arbiter.sv
// Credit-gated round-robin arbiter: one flit per cycle onto a shared downstream port,
// grant locked to the owner for the length of a multi-flit packet.
module crd_rr_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned CRD_CNT_MAX   = 4,
  parameter bit          CRD_INIT_FULL = 1'b1
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_rdy,
  input  logic               crd_rtn,
  output logic               out_vld,
  output logic [NUM_REQ-1:0] out_sel,
  output logic               out_last,
  output logic               crd_avail,
  output logic [3:0]         crd_cnt_bin,
  output logic               crd_ovf
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [PW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);
  localparam logic [CRD_CNT_MAX-1:0] THERMO_RST = CRD_INIT_FULL ? '1 : '0;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 r_state, w_state_nxt;
  idx_t                   r_ptr, w_ptr_nxt;
  idx_t                   r_owner, w_owner_nxt;
  logic [CRD_CNT_MAX-1:0] r_thermo;

  logic [NUM_REQ-1:0] w_gnt;
  idx_t               w_gnt_idx;
  idx_t               w_idx;
  logic               w_hit;
  logic               w_acc;
  logic               w_last;

  function automatic idx_t f_next(input idx_t i);
    return (i == LAST_IDX) ? '0 : idx_t'(i + 1'b1);
  endfunction

  assign crd_avail   = r_thermo[0];
  assign crd_cnt_bin = 4'($countones(r_thermo));
  assign w_acc       = |w_gnt;
  assign w_last      = |(w_gnt & req_last);

  // State register
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Next-state logic, advanced only on an accepted flit
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_acc) begin
      unique case (r_state)
        IDLE: begin
          if (w_last) begin
            w_ptr_nxt = f_next(w_gnt_idx);
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_gnt_idx;
          end
        end
        LOCKED: begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = f_next(r_owner);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Grant logic; gated by rstn so nothing is accepted while reset is held
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_hit     = 1'b0;
    w_idx     = r_ptr;
    if (rstn && crd_avail) begin
      if (r_state == LOCKED) begin
        if (req_vld[r_owner]) begin
          w_gnt[r_owner] = 1'b1;
          w_gnt_idx      = r_owner;
        end
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          if (!w_hit && req_vld[w_idx]) begin
            w_hit        = 1'b1;
            w_gnt[w_idx] = 1'b1;
            w_gnt_idx    = w_idx;
          end
          w_idx = f_next(w_idx);
        end
      end
    end
    req_rdy = w_gnt;
  end

  // Thermometer credit count: shift right on use, left on return, hold on both
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_thermo <= THERMO_RST;
      crd_ovf  <= 1'b0;
    end else if (w_acc && !crd_rtn) begin
      r_thermo <= r_thermo >> 1;
    end else if (crd_rtn && !w_acc) begin
      if (r_thermo[CRD_CNT_MAX-1]) crd_ovf <= 1'b1;
      else r_thermo <= (r_thermo << 1) | CRD_CNT_MAX'(1);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_sel  <= '0;
      out_last <= 1'b0;
    end else begin
      out_vld  <= w_acc;
      out_sel  <= w_gnt;
      out_last <= w_last;
    end
  end

endmodule

// File: tb/tb_crd_rr_arbiter.sv
// Randomized and directed bench for crd_rr_arbiter against an integer-level reference model.
module tb_crd_rr_arbiter;

  localparam int N   = 4;
  localparam int MAX = 4;

  logic         clock = 1'b0;
  logic         rstn;
  logic [N-1:0] req_vld, req_last, req_rdy, out_sel;
  logic         crd_rtn, out_vld, out_last, crd_avail, crd_ovf;
  logic [3:0]   crd_cnt_bin;

  logic [2:0]   d_rdy, d_sel;
  logic         d_vld, d_last, d_avail, d_ovf;
  logic [3:0]   d_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int m_cnt, m_ptr, m_owner;
  bit m_lock, m_ovf;

  crd_rr_arbiter #(.NUM_REQ(N), .CRD_CNT_MAX(MAX), .CRD_INIT_FULL(1'b1)) u_dut (
    .clock(clock), .rstn(rstn), .req_vld(req_vld), .req_last(req_last), .req_rdy(req_rdy),
    .crd_rtn(crd_rtn), .out_vld(out_vld), .out_sel(out_sel), .out_last(out_last),
    .crd_avail(crd_avail), .crd_cnt_bin(crd_cnt_bin), .crd_ovf(crd_ovf)
  );

  crd_rr_arbiter #(.NUM_REQ(3), .CRD_CNT_MAX(3), .CRD_INIT_FULL(1'b0)) u_dev (
    .clock(clock), .rstn(rstn), .req_vld(req_vld[2:0]), .req_last(req_last[2:0]), .req_rdy(d_rdy),
    .crd_rtn(crd_rtn), .out_vld(d_vld), .out_sel(d_sel), .out_last(d_last),
    .crd_avail(d_avail), .crd_cnt_bin(d_cnt), .crd_ovf(d_ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = MAX; m_ptr = 0; m_owner = 0; m_lock = 0; m_ovf = 0;
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] vld);
    logic [N-1:0] g = '0;
    if (m_cnt == 0) return g;
    if (m_lock) begin
      if (vld[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (vld[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // One clock: drive at negedge, check grant/credit state, then registered outputs after the edge
  task automatic cycle(input logic [N-1:0] vld, input logic [N-1:0] last, input logic rtn,
                       output logic [N-1:0] rdy_seen);
    logic [N-1:0] e_rdy;
    bit acc, e_last;
    int gi;
    @(negedge clock);
    req_vld = vld; req_last = last; crd_rtn = rtn;
    #1;
    e_rdy = model_grant(vld);
    rdy_seen = req_rdy;
    check("req_rdy", req_rdy, e_rdy);
    check("crd_cnt_bin", crd_cnt_bin, m_cnt);
    check("crd_avail", crd_avail, m_cnt > 0);
    check("crd_ovf", crd_ovf, m_ovf);
    acc = (e_rdy != 0);
    e_last = |(e_rdy & last);
    gi = 0;
    for (int i = 0; i < N; i++) if (e_rdy[i]) gi = i;
    @(posedge clock);
    if (acc && !rtn) m_cnt--;
    else if (rtn && !acc) begin
      if (m_cnt == MAX) m_ovf = 1;
      else m_cnt++;
    end
    if (acc) begin
      if (!m_lock) begin
        if (e_last) m_ptr = (gi + 1) % N;
        else begin m_lock = 1; m_owner = gi; end
      end else if (e_last) begin
        m_lock = 0; m_ptr = (m_owner + 1) % N;
      end
    end
    #1;
    check("out_vld", out_vld, acc);
    check("out_sel", out_sel, e_rdy);
    check("out_last", out_last, e_last);
  endtask

  logic [N-1:0] rdy;

  initial begin
    rstn = 1'b0; req_vld = '0; req_last = '0; crd_rtn = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_vld", out_vld, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_last", out_last, 0);
    check("rst_ovf", crd_ovf, 0);
    check("rst_cnt", crd_cnt_bin, MAX);
    check("dev_rst_cnt", d_cnt, 0);
    check("dev_rst_avail", d_avail, 0);
    req_vld = '1;
    #1;
    check("rst_rdy_gated", req_rdy, 0);
    @(negedge clock);
    req_vld = '0;
    rstn = 1'b1;

    // 1: drain all credits with single-flit packets from requester 0
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0001, 4'b0001, 1'b0, rdy);
      check("t1_gnt", rdy, 4'b0001);
      check("t1_cnt", crd_cnt_bin, 3 - i);
    end
    cycle(4'b0001, 4'b0001, 1'b0, rdy);
    check("t1_rdy0", rdy, 0);

    // 2: credit return becomes usable next cycle; return plus accept holds count
    cycle(4'b0001, 4'b0001, 1'b1, rdy);
    check("t2_noacc", rdy, 0);
    cycle(4'b0001, 4'b0001, 1'b0, rdy);
    check("t2_gnt", rdy, 4'b0001);
    check("t2_cnt0", crd_cnt_bin, 0);
    cycle(4'b0000, 4'b0000, 1'b1, rdy);
    cycle(4'b0001, 4'b0001, 1'b1, rdy);
    check("t2_same", crd_cnt_bin, 1);

    // 3: all requesting, single flits, credit back every cycle
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 4'b1111, 1'b1, rdy);
      check("t3_onehot", $countones(out_sel), 1);
      check("t3_cnt", crd_cnt_bin, 1);
    end

    // 4: requester 1 locks for a 3-flit packet, requester 2 waits
    cycle(4'b0010, 4'b0000, 1'b1, rdy);
    check("t4_f1", rdy, 4'b0010);
    cycle(4'b0110, 4'b0000, 1'b1, rdy);
    check("t4_f2", rdy, 4'b0010);
    cycle(4'b0110, 4'b0010, 1'b1, rdy);
    check("t4_f3", rdy, 4'b0010);
    cycle(4'b1111, 4'b1111, 1'b1, rdy);
    check("t4_ptr2", rdy, 4'b0100);

    // 5: fill credits, then overflow
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1, rdy);
    check("t5_full", crd_cnt_bin, MAX);
    cycle(4'b0000, 4'b0000, 1'b1, rdy);
    check("t5_ovf", crd_ovf, 1);
    check("t5_cnt", crd_cnt_bin, MAX);

    for (int i = 0; i < 1500; i++)
      cycle(N'($urandom), N'($urandom), 1'($urandom), rdy);
    check("t5_sticky", crd_ovf, 1);

    // 6: reset mid-packet with one credit left
    rstn = 1'b0; #1; rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(4'b0001, 4'b0000, 1'b0, rdy);
    @(negedge clock);
    req_vld = 4'b0001;
    #2;
    check("t6_pre_vld", out_vld, 1);
    check("t6_pre_cnt", crd_cnt_bin, 1);
    rstn = 1'b0;
    #1;
    check("t6_out_vld", out_vld, 0);
    check("t6_rdy", req_rdy, 0);
    check("t6_cnt", crd_cnt_bin, MAX);
    check("t6_ovf", crd_ovf, 0);
    @(posedge clock);
    #2;
    rstn = 1'b1;
    model_reset();
    cycle(4'b0110, 4'b0000, 1'b0, rdy);
    check("t6_other", rdy, 4'b0010);

    for (int i = 0; i < 1500; i++)
      cycle(N'($urandom), N'($urandom_range(0, 1) ? $urandom : 0), 1'($urandom), rdy);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
